// File: rtl/vth_read_sense_pkg.sv
// Shared definitions for the voltage-program channel stages.
// Threshold width, stored-level encoding and read-sense FSM states.
package vth_read_sense_pkg;

  localparam int VTH_W = 16;

  typedef logic [1:0] level_t;

  localparam level_t LVL_ERASED = 2'd0;
  localparam level_t LVL_P1     = 2'd1;
  localparam level_t LVL_P2     = 2'd2;
  localparam level_t LVL_P3     = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_SENSE_MID  = 2'd1;
  localparam state_t ST_SENSE_SIDE = 2'd2;
  localparam state_t ST_DONE       = 2'd3;

endpackage

// File: rtl/vth_read_sense_sat_counter.sv
// Saturating event counter; clear is applied before the increment,
// so a clear and an increment in the same cycle leave a count of 1.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vth_read_sense.sv
// Read-sense stage: 2-step binary search of a cell Vth against three
// latched references, with mis-read detection and a saturating counter.
module vth_read_sense #(
  parameter int VTH_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VTH_W-1:0] vth_in,
  input  logic [1:0]       written_level,
  input  logic             vth_valid,
  output logic             vth_ready,
  input  logic [VTH_W-1:0] vref0,
  input  logic [VTH_W-1:0] vref1,
  input  logic [VTH_W-1:0] vref2,
  output logic [1:0]       read_level,
  output logic             level_error,
  output logic             read_valid,
  input  logic             read_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] error_count
);

  import vth_read_sense_pkg::*;

  state_t           state;
  logic [VTH_W-1:0] vth_q;
  logic [VTH_W-1:0] ref0_q;
  logic [VTH_W-1:0] ref1_q;
  logic [VTH_W-1:0] ref2_q;
  level_t           wl_q;
  logic             msb_q;

  logic   accept;
  logic   lsb;
  logic   mismatch;
  logic   count_inc;

  assign accept    = vth_ready & vth_valid;
  assign lsb       = vth_q >= (msb_q ? ref2_q : ref0_q);
  assign mismatch  = {msb_q, lsb} != wl_q;
  assign count_inc = (state == ST_SENSE_SIDE) & mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      vth_ready   <= 1'b0;
      read_valid  <= 1'b0;
      read_level  <= LVL_ERASED;
      level_error <= 1'b0;
      msb_q       <= 1'b0;
      vth_q       <= '0;
      ref0_q      <= '0;
      ref1_q      <= '0;
      ref2_q      <= '0;
      wl_q        <= LVL_ERASED;
    end else begin
      unique case (state)
        ST_IDLE: begin
          vth_ready <= 1'b1;
          if (accept) begin
            vth_q     <= vth_in;
            wl_q      <= written_level;
            ref0_q    <= vref0;
            ref1_q    <= vref1;
            ref2_q    <= vref2;
            vth_ready <= 1'b0;
            state     <= ST_SENSE_MID;
          end
        end
        ST_SENSE_MID: begin
          msb_q <= vth_q >= ref1_q;
          state <= ST_SENSE_SIDE;
        end
        ST_SENSE_SIDE: begin
          read_level  <= {msb_q, lsb};
          level_error <= mismatch;
          read_valid  <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (read_ready) begin
            read_valid <= 1'b0;
            vth_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (err_clr),
    .inc  (count_inc),
    .count(error_count)
  );

endmodule

// File: doc/vth_read_sense.md
Name: vth_read_sense

Overview:
- Downstream stage of the voltage-program channel model; consumes the 16-bit programmed threshold voltage (InitialVth) of one cell.
- Senses the cell against three latched read-reference voltages using a 2-step binary search, one compare per cycle.
- Returns the detected 2-bit level, compares it with the level originally written, and keeps a saturating mis-read counter for raw-BER measurement.

Parameters:
- VTH_W, 16, width of threshold-voltage samples and read references (unsigned).
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- vth_in  input  VTH_W  cell threshold voltage from the program stage.
- written_level  input  2  VoltageLevel that was programmed into the cell.
- vth_valid  input  1  vth_in/written_level valid.
- vth_ready  output  1  stage can accept a sample.
- vref0, vref1, vref2  input  VTH_W  read references; require vref0 < vref1 < vref2.
- read_level  output  2  sensed level.
- level_error  output  1  read_level != written level.
- read_valid  output  1  result valid.
- read_ready  input  1  consumer accepts the result.
- err_clr  input  1  clear error counter.
- error_count  output  CNT_W  saturating count of mis-reads.

Behaviour:
- Reset values: vth_ready=0, read_valid=0, read_level=0, level_error=0, error_count=0, FSM=IDLE. Reset mid-operation aborts the in-flight sample with no result and no count update.
- FSM states: IDLE, SENSE_MID, SENSE_SIDE, DONE.
- IDLE: vth_ready=1. On vth_valid, latch vth_in, written_level and all three vrefs, then go to SENSE_MID. Later vref changes do not affect the in-flight sample.
- SENSE_MID: compare the latched Vth with vref1 and record the result as msb (msb = Vth >= vref1). Go to SENSE_SIDE.
- SENSE_SIDE: compare against vref2 if msb=1, else against vref0. Record lsb (lsb = Vth >= selected ref). Register read_level={msb,lsb} and level_error. Go to DONE.
- DONE: read_valid=1. read_level and level_error stay stable until read_ready=1. On that cycle, return to IDLE; vth_ready rises the next cycle.
- Latency: acceptance in cycle N gives read_valid=1 in cycle N+3. Minimum initiation interval is 4 cycles with read_ready held high.
- Level mapping:
  - Vth < vref0 gives 0.
  - vref0 <= Vth < vref1 gives 1.
  - vref1 <= Vth < vref2 gives 2.
  - Vth >= vref2 gives 3.
  - Equality always resolves upward.
  - Compares are unsigned and full width. No arithmetic, so no overflow is possible.
- error_count:
  - Increments by 1 in the SENSE_SIDE->DONE transition cycle when a mismatch is found.
  - Saturates at 2^CNT_W-1.
  - err_clr=1 sets it to 0. If err_clr and an increment occur in the same cycle, the result is 1 (clear first, then count).
- Extreme values: vth_in=0 reads level 0; vth_in=all-ones reads level 3.
- vth_valid while vth_ready=0 is ignored; the upstream stage must hold it.
- Misordered vrefs are not checked. The result is simply whatever the compare path described above produces.

Decomposition:
- Shared package, reused by the voltage-program and later stages:
  - VTH_W
  - level typedef (2 bits) with constants LVL_ERASED=0, LVL_P1=1, LVL_P2=2, LVL_P3=3
  - FSM state enum.
- One natural sub-module: sat_counter, a CNT_W-wide saturating counter with clear and increment inputs (clear has priority, then increment applied).

Test Plan:
- Use vref0/1/2=0x4000/0x8000/0xC000 for all scenarios.
- Nominal read: vth_in=0x9000, written_level=2. Expect read_valid 3 cycles after accept, read_level=2, level_error=0, error_count unchanged.
- Boundary equality: vth_in=0x4000, 0x8000, 0xC000 and 0xFFFF in turn. Expect levels 1, 2, 3, 3. Also vth_in=0x3FFF gives level 0.
- Mis-read and saturation:
  - vth_in=0x3000 with written_level=1 gives level_error=1 and count 1.
  - Preload to 0xFFFE, then two more mis-reads; count holds at 0xFFFF.
  - err_clr pulsed in the same cycle as a mis-read gives count 1.
- Backpressure: hold read_ready=0 for 10 cycles. read_valid and read_level stay stable, vth_ready=0, new vth_valid is ignored. Releasing read_ready resumes, and vth_ready=1 the next cycle.
- Reference latching: change vref1 to 0x1000 during SENSE_MID for vth_in=0x7000. The result is still level 1.
- Reset mid-operation: assert reset in SENSE_SIDE. The next cycle shows all outputs at reset values, error_count=0, and no read_valid pulse.
